// File: rtl/alu_issue_ctrl.sv
// Issue/writeback control stage in front of a combinational 32-bit ALU.
// Decodes one instruction per transaction, drives the ALU, writes back results and flags.
module alu_issue_ctrl #(
  parameter int unsigned NREGS        = 8,
  parameter logic [15:0] RESET_PC_TAG = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_op,
  output logic        alu_cin,
  input  logic [31:0] alu_res,
  input  logic        alu_cout,
  output logic        done,
  output logic        illegal,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n,
  output logic [15:0] retired,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_SLL = 6'b110000;
  localparam logic [5:0] OP_SRL = 6'b110001;
  localparam logic [5:0] OP_SRA = 6'b110010;

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] regs_q [NREGS];
  logic [31:0] res_q;
  logic        cout_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [5:0]  alu_op_q;
  logic        alu_cin_q;
  logic        flag_c_q, flag_z_q, flag_n_q;
  logic [15:0] retired_q;

  logic [5:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic        use_carry, imm_sel;
  logic [14:0] imm;
  logic        opcode_legal;
  logic [31:0] rs1_val, rs2_val;

  assign opcode    = instr_q[31:26];
  assign rd        = instr_q[25:23];
  assign rs1       = instr_q[22:20];
  assign rs2       = instr_q[19:17];
  assign use_carry = instr_q[16];
  assign imm_sel   = instr_q[15];
  assign imm       = instr_q[14:0];

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_EQ, OP_SLL, OP_SRL, OP_SRA: opcode_legal = 1'b1;
      default:                                        opcode_legal = 1'b0;
    endcase
  end

  // Register 0 is hard-wired to zero on every read port.
  assign rs1_val  = (rs1 == '0)      ? '0 : regs_q[rs1];
  assign rs2_val  = (rs2 == '0)      ? '0 : regs_q[rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = DECODE;
      DECODE:  state_d = opcode_legal ? EXEC : ERR;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == WB);
  assign illegal     = (state_q == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid) instr_q <= instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_cin_q <= 1'b0;
      res_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      if (state_q == DECODE && opcode_legal) begin
        alu_op_q  <= opcode;
        alu_a_q   <= rs1_val;
        alu_b_q   <= imm_sel ? {17'b0, imm} : rs2_val;
        alu_cin_q <= use_carry & flag_c_q;
      end
      if (state_q == EXEC) begin
        res_q  <= alu_res;
        cout_q <= alu_cout;
      end
    end
  end

  // Architectural state only changes on the edge that leaves WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      retired_q <= RESET_PC_TAG;
    end else if (state_q == WB) begin
      if (rd != '0) regs_q[rd] <= res_q;
      flag_z_q  <= (res_q == '0);
      flag_n_q  <= res_q[31];
      if (alu_op_q == OP_ADD || alu_op_q == OP_SUB) flag_c_q <= cout_q;
      retired_q <= retired_q + 16'd1;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign alu_cin = alu_cin_q;
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
  assign flag_n  = flag_n_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a transaction-level model checked every cycle,
// plus directed instruction sequences with hand-computed register/flag values.
module tb_alu_issue_ctrl;

  localparam logic [5:0] ADD = 6'b010000;
  localparam logic [5:0] SUB = 6'b010001;
  localparam logic [5:0] EQ  = 6'b100000;
  localparam logic [5:0] SLL = 6'b110000;
  localparam logic [5:0] SRL = 6'b110001;
  localparam logic [5:0] SRA = 6'b110010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_op;
  logic        alu_cin;
  logic [31:0] alu_res;
  logic        alu_cout;
  logic        done, illegal, flag_c, flag_z, flag_n;
  logic [15:0] retired;
  logic [2:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREGS(8), .RESET_PC_TAG(16'd0)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_cin(alu_cin), .alu_res(alu_res), .alu_cout(alu_cout), .done(done),
    .illegal(illegal), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU: {carry/borrow, result}.
  function automatic logic [32:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
    logic [32:0] r;
    logic [31:0] t;
    r = '0;
    case (op)
      ADD: r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      SUB: r = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      EQ:  r = {32'd0, a == b};
      SLL: r = {1'b0, a << b[4:0]};
      SRL: r = {1'b0, a >> b[4:0]};
      SRA: begin t = $signed(a) >>> b[4:0]; r = {1'b0, t}; end
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {alu_cout, alu_res} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

  function automatic logic is_legal(input logic [5:0] op);
    return op == ADD || op == SUB || op == EQ || op == SLL || op == SRL || op == SRA;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic uc, input logic is, input logic [14:0] imm);
    return {op, rd, rs1, rs2, uc, is, imm};
  endfunction

  // Transaction model: one instruction in flight, counted in edges since acceptance.
  logic [31:0] m_regs [8];
  logic        m_c, m_z, m_n;
  logic [15:0] m_ret;
  logic [31:0] e_a, e_b;
  logic [5:0]  e_op;
  logic        e_cin;
  logic        pend;
  int          since;
  logic [31:0] p_ins;
  logic [32:0] m_r;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_ret = 16'd0;
    e_a = '0; e_b = '0; e_op = '0; e_cin = 1'b0;
    pend = 1'b0; since = 0; p_ins = '0;
  endtask

  task automatic model_step();
    if (!rst_n) model_reset();
    else if (pend) begin
      since++;
      if (is_legal(p_ins[31:26])) begin
        if (since == 1) begin
          e_op  = p_ins[31:26];
          e_a   = m_regs[p_ins[22:20]];
          e_b   = p_ins[15] ? {17'd0, p_ins[14:0]} : m_regs[p_ins[19:17]];
          e_cin = p_ins[16] & m_c;
        end
        if (since == 3) begin
          m_r = alu_fn(e_op, e_a, e_b, e_cin);
          if (p_ins[25:23] != 3'd0) m_regs[p_ins[25:23]] = m_r[31:0];
          m_z = (m_r[31:0] == 32'd0);
          m_n = m_r[31];
          if (e_op == ADD || e_op == SUB) m_c = m_r[32];
          m_ret = m_ret + 16'd1;
          pend = 1'b0;
        end
      end else if (since == 2) pend = 1'b0;
    end else if (instr_valid) begin
      pend = 1'b1; since = 0; p_ins = instr;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    logic legal;
    legal = is_legal(p_ins[31:26]);
    chk("ready",   32'(instr_ready), 32'(!pend));
    chk("done",    32'(done),        32'(pend && legal && since == 2));
    chk("illegal", 32'(illegal),     32'(pend && !legal && since == 1));
    chk("flag_c",  32'(flag_c),      32'(m_c));
    chk("flag_z",  32'(flag_z),      32'(m_z));
    chk("flag_n",  32'(flag_n),      32'(m_n));
    chk("retired", 32'(retired),     32'(m_ret));
    chk("alu_a",   alu_a,            e_a);
    chk("alu_b",   alu_b,            e_b);
    chk("alu_op",  32'(alu_op),      32'(e_op));
    chk("alu_cin", 32'(alu_cin),     32'(e_cin));
    chk("dbg",     dbg_data,         m_regs[dbg_addr]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    dbg_addr = dbg_addr + 3'd1;
  endtask

  task automatic lit_reg(input logic [2:0] a, input logic [31:0] v);
    dbg_addr = a;
    #1;
    chk($sformatf("R%0d", a), dbg_data, v);
    chk($sformatf("model_R%0d", a), m_regs[a], v);
  endtask

  // Presents w while idle; lat counts cycles from the presentation cycle (lat 0).
  task automatic issue(input logic [31:0] w, input logic hold, input logic [31:0] hold_w,
                       input logic legal);
    int lat, ld, li, lr;
    lat = 0; ld = -1; li = -1; lr = -1;
    instr = w; instr_valid = 1'b1;
    cyc(); lat = 1;
    if (hold) instr = hold_w;
    else instr_valid = 1'b0;
    while (lat < 20) begin
      if (done && ld < 0) ld = lat;
      if (illegal && li < 0) li = lat;
      if (instr_ready) begin lr = lat; break; end
      cyc(); lat++;
    end
    instr_valid = 1'b0;
    chk("done_lat",  32'(ld), legal ? 32'd3 : 32'hFFFFFFFF);
    chk("ill_lat",   32'(li), legal ? 32'hFFFFFFFF : 32'd2);
    chk("ready_lat", 32'(lr), legal ? 32'd4 : 32'd3);
  endtask

  initial begin
    model_reset();
    cyc(); cyc();
    chk("rst_ready",   32'(instr_ready), 32'd1);
    chk("rst_done",    32'(done),        32'd0);
    chk("rst_retired", 32'(retired),     32'd0);
    chk("rst_alu_a",   alu_a,            32'd0);
    rst_n = 1'b1;
    cyc();

    // Reset while the instruction sits in EXEC.
    instr = mk(ADD, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 15'd9);
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("midrst_done", 32'(done), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    lit_reg(3'd3, 32'd0);
    chk("midrst_retired", 32'(retired), 32'd0);

    issue(mk(ADD, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 15'd5), 1'b0, '0, 1'b1);
    issue(mk(ADD, 3'd2, 3'd1, 3'd0, 1'b0, 1'b1, 15'h7FFF), 1'b0, '0, 1'b1);
    lit_reg(3'd2, 32'h0000_8004);
    chk("add_c", 32'(flag_c), 32'd0);
    chk("add_z", 32'(flag_z), 32'd0);
    chk("add_n", 32'(flag_n), 32'd0);

    issue(mk(SUB, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 15'd1), 1'b0, '0, 1'b1);
    lit_reg(3'd1, 32'hFFFF_FFFF);
    issue(mk(ADD, 3'd3, 3'd1, 3'd0, 1'b0, 1'b1, 15'd1), 1'b0, '0, 1'b1);
    lit_reg(3'd3, 32'd0);
    chk("carry_c", 32'(flag_c), 32'd1);
    chk("carry_z", 32'(flag_z), 32'd1);
    issue(mk(ADD, 3'd4, 3'd0, 3'd0, 1'b1, 1'b1, 15'd0), 1'b0, '0, 1'b1);
    lit_reg(3'd4, 32'd1);
    chk("cin_seen", 32'(alu_cin), 32'd1);
    chk("cin_c",    32'(flag_c),  32'd0);

    issue(mk(SUB, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 15'd1), 1'b0, '0, 1'b1);
    lit_reg(3'd5, 32'hFFFF_FFFF);
    chk("borrow_n", 32'(flag_n), 32'd1);
    chk("borrow_c", 32'(flag_c), 32'd1);

    issue(mk(ADD, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 15'd1), 1'b0, '0, 1'b1);
    issue(mk(SUB, 3'd6, 3'd0, 3'd0, 1'b0, 1'b1, 15'd1), 1'b0, '0, 1'b1);
    issue(mk(SLL, 3'd1, 3'd1, 3'd0, 1'b0, 1'b1, 15'd31), 1'b0, '0, 1'b1);
    lit_reg(3'd1, 32'h8000_0000);
    issue(mk(SRA, 3'd7, 3'd1, 3'd0, 1'b0, 1'b1, 15'd4), 1'b0, '0, 1'b1);
    lit_reg(3'd7, 32'hF800_0000);
    chk("sra_n", 32'(flag_n), 32'd1);
    issue(mk(SRL, 3'd6, 3'd1, 3'd0, 1'b0, 1'b1, 15'd4), 1'b0, '0, 1'b1);
    lit_reg(3'd6, 32'h0800_0000);
    issue(mk(EQ, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 15'd0), 1'b0, '0, 1'b1);
    lit_reg(3'd2, 32'd1);
    chk("c_kept", 32'(flag_c), 32'd1);
    chk("ret12",  32'(retired), 32'd12);

    issue(mk(6'b000000, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 15'd7), 1'b0, '0, 1'b0);
    issue(mk(6'b010010, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 15'd7), 1'b0, '0, 1'b0);
    chk("ill_retired", 32'(retired), 32'd12);
    lit_reg(3'd3, 32'd0);

    // valid held through the busy cycles with a different word on the bus
    issue(mk(ADD, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 15'd3), 1'b1,
          mk(ADD, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 15'h55), 1'b1);
    cyc(); cyc();
    lit_reg(3'd2, 32'd3);
    lit_reg(3'd5, 32'hFFFF_FFFF);
    chk("hold_retired", 32'(retired), 32'd13);

    issue(mk(ADD, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 15'd0), 1'b0, '0, 1'b1);
    chk("zero_z", 32'(flag_z), 32'd1);
    issue(mk(ADD, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 15'd7), 1'b0, '0, 1'b1);
    lit_reg(3'd0, 32'd0);
    chk("r0_z",   32'(flag_z),  32'd0);
    chk("ret15",  32'(retired), 32'd15);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle control stage directly upstream of the 32-bit ALU.
- Accepts one instruction word per transaction over a valid/ready handshake and decodes it into ALU opCode, operands and carry-in.
- Samples the ALU result and flags, writes the result back to an 8-entry register file, and holds the C/Z/N status flags.

Parameters:
- NREGS, 8, number of 32-bit general registers; index width is 3 bits.
- RESET_PC_TAG, 0, reset value of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word present
- instr  in  32  [31:26] opcode, [25:23] rd, [22:20] rs1, [19:17] rs2, [16] use_carry, [15] imm_sel, [14:0] imm (zero-extended)
- instr_ready  out  1  block can accept an instruction
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_op  out  6  ALU opCode
- alu_cin  out  1  ALU carry/borrow in
- alu_res  in  32  ALU ans1
- alu_cout  in  1  ALU ans2 (carry/borrow out)
- done  out  1  one-cycle pulse on writeback
- illegal  out  1  one-cycle pulse on an undefined opcode
- flag_c, flag_z, flag_n  out  1 each  status flags
- retired  out  16  count of completed legal instructions
- dbg_addr  in  3  debug register select
- dbg_data  out  32  combinational read of register dbg_addr

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all registers, alu_a, alu_b, alu_op, alu_cin, flags and done/illegal go to 0.
  - retired goes to RESET_PC_TAG.
  - Reset mid-transaction abandons the instruction with no writeback.
- Legal opcodes: 010000 add, 010001 sub, 100000 equal, 110000 shift-left logical, 110001 shift-right logical, 110010 shift-right arithmetic. All others are illegal.
- FSM states: IDLE, DECODE, EXEC, WB, ERR.
- IDLE:
  - instr_ready = 1 only in this state.
  - On instr_valid & instr_ready, latch instr and go to DECODE.
  - instr_valid without ready is ignored; no latching.
- DECODE:
  - Illegal opcode: go to ERR.
  - Legal opcode, registered this edge:
    - alu_op = opcode
    - alu_a = R[rs1]
    - alu_b = imm_sel ? {17'b0, imm} : R[rs2]
    - alu_cin = use_carry & flag_c
  - Then go to EXEC.
- EXEC: the ALU is combinational; capture alu_res and alu_cout, go to WB.
- WB:
  - Write the result to R[rd] unless rd = 0.
  - done = 1 for this cycle only.
  - Update flags:
    - flag_z = (result == 0)
    - flag_n = result[31]
    - flag_c = alu_cout for add/sub only; flag_c unchanged for other ops.
  - retired += 1, wrapping modulo 2^16.
  - Go to IDLE.
- ERR:
  - illegal = 1 for one cycle.
  - No register, flag or retired change.
  - Go to IDLE.
- Latency: handshake at edge T → done high in cycle T+3 → instr_ready high again in cycle T+4. Throughput is one instruction per 4 cycles; an illegal instruction takes 3 cycles.
- Register 0 always reads 0; writes to it are dropped, but flags still update.
- alu_* outputs hold their last values outside DECODE.
- Read-after-write: an instruction accepted right after WB sees the written value, because the register file is written at the WB edge, before the next DECODE.
- dbg_data reflects the register file contents combinationally; a same-cycle write is visible only after the edge.

Test Plan:
- Reset then idle:
  - Check all outputs are 0 and instr_ready = 1.
  - Drive rst_n low in the middle of EXEC → state IDLE, no done pulse, destination register unchanged.
- Add immediate:
  - R1 ← add r0 + imm 5.
  - R2 ← add r1 + imm 0x7FFF.
  - → dbg R2 = 0x8004; done exactly 3 cycles after each handshake; C = 0, Z = 0, N = 0.
- Carry chain:
  - Preload R1 = 0xFFFFFFFF.
  - add R3 = R1 + imm 1 → R3 = 0, C = 1, Z = 1.
  - Then add with use_carry, R4 = r0 + imm 0 → R4 = 1, alu_cin observed 1, C = 0.
- Subtract with borrow: R5 = r0 − imm 1 → R5 = 0xFFFFFFFF, N = 1, C = 1.
- Shifts and compare:
  - R1 = 0x80000000 (built with shift-left of imm 1 by imm 31).
  - Shift-right arithmetic by 4 → 0xF8000000.
  - Shift-right logical by 4 → 0x08000000.
  - equal(R1, R1) → 1.
  - Check C unchanged across all of these.
- Illegal and handshake:
  - Opcode 000000 → illegal pulse, done = 0, retired unchanged, ready again after 3 cycles.
  - Holding instr_valid high during busy cycles latches nothing extra.
  - Write to rd = 0 leaves dbg R0 = 0.
